vending_customer: RTL
=====================

VENDING_CUSTOMER -- requirements
Module: vending_customer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port i_req_valid, input, 1 bit: purchase request present.
REQ-004 SHALL have port i_req_item, input, kNumItems bits: one-hot item requested; sampled when the request is accepted.
REQ-005 SHALL have port o_req_ready, output, 1 bit: high only in IDLE.
REQ-006 SHALL have port i_wallet_load, input, 1 bit: load wallet counts; honoured only in IDLE.
REQ-007 SHALL have port i_wallet_count, input, kNumCoins*8 bits: per-coin counts, coin 0 in bits [7:0].
REQ-008 SHALL have port o_input_coin, output, kNumCoins bits: one-hot coin insert pulse to the machine.
REQ-009 SHALL have port o_select_item, output, kNumItems bits: one-hot item select pulse to the machine.
REQ-010 SHALL have port o_trigger_return, output, 1 bit: change-return request to the machine.
REQ-011 SHALL have port i_available_item, input, kNumItems bits: machine availability.
REQ-012 SHALL have port i_output_item, input, kNumItems bits: machine item dispensed.
REQ-013 SHALL have port i_return_coin, input, kNumCoins bits: machine coin returned, one bit per coin per cycle.
REQ-014 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port o_status, output, 2 bits: 0 OK, 1 NO_FUNDS, 2 TIMEOUT; valid while o_done=1.
REQ-016 SHALL have port o_wallet_total, output, kTotalBits bits: sum of count*coin value over all coins.

Function
REQ-017 SHALL implement FSM states IDLE, INSERT, CHECK, SELECT, WAIT_ITEM, RETURN, DONE.
REQ-018 IDLE: i_req_valid=1 with exactly one i_req_item bit set SHALL latch the item and go to CHECK; a zero or multi-hot request SHALL be ignored.
REQ-019 CHECK: if i_available_item & item is non-zero, SHALL go to SELECT; otherwise, if any wallet count is non-zero, go to INSERT; otherwise go to RETURN with status NO_FUNDS.
REQ-020 INSERT: SHALL pulse o_input_coin for exactly one cycle for the highest-value coin with non-zero count, decrement that count, then go to CHECK.
REQ-021 The INSERT/CHECK alternation SHALL give the machine's registered balance one cycle to update before availability is sampled.
REQ-022 SELECT: SHALL pulse o_select_item=item for one cycle, then go to WAIT_ITEM with the timeout counter cleared.
REQ-023 WAIT_ITEM: i_output_item==item SHALL set status OK and go to RETURN.
REQ-024 WAIT_ITEM: if the item is not seen within 4 cycles, SHALL set status TIMEOUT and go to RETURN.
REQ-025 RETURN: SHALL hold o_trigger_return=1.
REQ-026 RETURN: each set i_return_coin bit SHALL increment the matching wallet count, saturating at 255.
REQ-027 RETURN: SHALL exit to DONE after 2 consecutive cycles with i_return_coin=0, counted from the first RETURN cycle.
REQ-028 DONE: SHALL assert o_done for one cycle, then go to IDLE.
REQ-029 Outside their designated states, o_input_coin, o_select_item and o_trigger_return SHALL be 0; at most one of them SHALL be non-zero in any cycle.
REQ-030 o_wallet_total SHALL be combinational from the wallet counts, computed at kTotalBits width with no overflow.
REQ-031 i_wallet_load outside IDLE SHALL be ignored; i_wallet_load together with an accepted request in IDLE SHALL load the counts first, and the purchase SHALL use the loaded counts.

Reset
REQ-032 reset=1 SHALL immediately force state IDLE, all wallet counts 0, status 0, and all outputs 0 except o_req_ready=1.
REQ-033 Reset mid-purchase SHALL abandon the purchase with no o_done pulse and no return trigger.

Structure
REQ-034 kNumCoins=3, kNumItems=4, kTotalBits=31, coin values {100,500,1000}, item prices {400,500,1000,2000} and the status encodings SHALL live in the shared vending_machine_def include.
REQ-035 Wallet storage, greedy coin pick, return accumulation and o_wallet_total SHALL be one sub-module, customer_wallet; the FSM SHALL live in vending_customer.

Verification
REQ-036 Wallet {0,1,0}, request item 0 (price 400), connected to vending_machine -> one 500 insert, select, item 0 received, returned coin 100 gives wallet {1,0,0}, o_status=0.
REQ-037 Wallet {4,0,0}, request item 0 -> four 100 inserts on alternate cycles, then SELECT; o_wallet_total=0 before the return phase.
REQ-038 Wallet {1,0,0}, request item 3 (price 2000) -> one insert, NO_FUNDS, trigger return, 100 refunded, final wallet {1,0,0}, o_status=1.
REQ-039 Stub machine that never asserts i_output_item -> o_status=2 exactly 4 cycles after SELECT leads to RETURN, then o_done.
REQ-040 reset asserted during INSERT -> all outputs 0 immediately, o_req_ready=1, o_wallet_total=0, no o_done pulse.
REQ-041 Request with i_req_item=4'b0011 -> ignored; o_req_ready stays 1 and no coin is inserted.

Source files
------------

// File: rtl/vending_customer_pkg.sv
// Shared definitions for the vending customer: sizes, coin and item values,
// status and state encodings.
package vending_customer_pkg;

  localparam int kNumCoins    = 3;
  localparam int kNumItems    = 4;
  localparam int kTotalBits   = 31;
  localparam int kCountBits   = 8;
  localparam int kWaitCycles  = 4;
  localparam int kQuietCycles = 2;

  typedef enum logic [1:0] {
    STATUS_OK       = 2'd0,
    STATUS_NO_FUNDS = 2'd1,
    STATUS_TIMEOUT  = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INSERT    = 3'd1,
    S_CHECK     = 3'd2,
    S_SELECT    = 3'd3,
    S_WAIT_ITEM = 3'd4,
    S_RETURN    = 3'd5,
    S_DONE      = 3'd6
  } state_e;

  // Coins are indexed in ascending value order; the greedy pick relies on it.
  function automatic logic [kTotalBits-1:0] coin_value(input int idx);
    case (idx)
      0:       coin_value = 31'd100;
      1:       coin_value = 31'd500;
      2:       coin_value = 31'd1000;
      default: coin_value = '0;
    endcase
  endfunction

  function automatic logic [kTotalBits-1:0] item_price(input int idx);
    case (idx)
      0:       item_price = 31'd400;
      1:       item_price = 31'd500;
      2:       item_price = 31'd1000;
      3:       item_price = 31'd2000;
      default: item_price = '0;
    endcase
  endfunction

  function automatic logic is_single_item(input logic [kNumItems-1:0] v);
    is_single_item = $onehot(v);
  endfunction

endpackage

// File: rtl/vending_customer_wallet.sv
// Customer wallet: per-coin counts, greedy highest-value coin pick, saturating
// refund accumulation and the combinational wallet value.
module customer_wallet
  import vending_customer_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_load,
  input  logic [kNumCoins*kCountBits-1:0] i_load_count,
  input  logic                            i_dec,
  input  logic                            i_ret_en,
  input  logic [kNumCoins-1:0]            i_ret_coin,
  output logic [kNumCoins-1:0]            o_pick,
  output logic                            o_any,
  output logic [kTotalBits-1:0]           o_total
);

  logic [kCountBits-1:0] r_count [kNumCoins];
  logic [kNumCoins-1:0]  w_pick;
  logic                  w_any;
  logic [kTotalBits-1:0] w_total;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < kNumCoins; c++) r_count[c] <= '0;
    end else if (i_load) begin
      for (int c = 0; c < kNumCoins; c++)
        r_count[c] <= i_load_count[c*kCountBits +: kCountBits];
    end else begin
      for (int c = 0; c < kNumCoins; c++) begin
        if (i_dec && w_pick[c])
          r_count[c] <= r_count[c] - 8'd1;
        else if (i_ret_en && i_ret_coin[c] && (r_count[c] != 8'hFF))
          r_count[c] <= r_count[c] + 8'd1;
      end
    end
  end

  // Later (higher-value) coins override earlier ones, leaving the richest non-empty coin.
  always_comb begin
    w_pick = '0;
    w_any  = 1'b0;
    for (int c = 0; c < kNumCoins; c++) begin
      if (r_count[c] != '0) begin
        w_pick    = '0;
        w_pick[c] = 1'b1;
        w_any     = 1'b1;
      end
    end
  end

  always_comb begin
    w_total = '0;
    for (int c = 0; c < kNumCoins; c++)
      w_total = w_total + kTotalBits'(r_count[c]) * coin_value(c);
  end

  assign o_pick  = w_pick;
  assign o_any   = w_any;
  assign o_total = w_total;

endmodule

// File: rtl/vending_customer.sv
// Customer-side purchase sequencer: inserts coins greedily until the machine
// offers the item, selects it, waits for delivery, then collects the change.
//
// state     | meaning
// IDLE      | ready for a request; wallet may be loaded
// INSERT    | one coin insert pulse on the machine
// CHECK     | machine balance has settled; decide select / insert / give up
// SELECT    | one item select pulse
// WAIT_ITEM | wait up to kWaitCycles for delivery
// RETURN    | hold change-return until the coin stream goes quiet
// DONE      | one-cycle completion pulse
module vending_customer
  import vending_customer_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_req_valid,
  input  logic [kNumItems-1:0]            i_req_item,
  output logic                            o_req_ready,
  input  logic                            i_wallet_load,
  input  logic [kNumCoins*kCountBits-1:0] i_wallet_count,
  output logic [kNumCoins-1:0]            o_input_coin,
  output logic [kNumItems-1:0]            o_select_item,
  output logic                            o_trigger_return,
  input  logic [kNumItems-1:0]            i_available_item,
  input  logic [kNumItems-1:0]            i_output_item,
  input  logic [kNumCoins-1:0]            i_return_coin,
  output logic                            o_done,
  output logic [1:0]                      o_status,
  output logic [kTotalBits-1:0]           o_wallet_total
);

  state_e               r_state;
  logic [kNumItems-1:0] r_item;
  logic [1:0]           r_wait_timer;
  logic                 r_quiet_timer;
  status_e              r_status;
  logic                 r_req_ready;
  logic [kNumCoins-1:0] r_input_coin;
  logic [kNumItems-1:0] r_select_item;
  logic                 r_trigger_return;
  logic                 r_done;

  logic                 w_avail;
  logic                 w_any;
  logic [kNumCoins-1:0] w_pick;
  logic                 w_load;
  logic                 w_dec;
  logic                 w_ret_en;

  assign w_avail  = |(i_available_item & r_item);
  assign w_load   = i_wallet_load && (r_state == S_IDLE);
  assign w_dec    = (r_state == S_CHECK) && !w_avail && w_any;
  assign w_ret_en = (r_state == S_RETURN);

  customer_wallet u_wallet (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_load_count (i_wallet_count),
    .i_dec        (w_dec),
    .i_ret_en     (w_ret_en),
    .i_ret_coin   (i_return_coin),
    .o_pick       (w_pick),
    .o_any        (w_any),
    .o_total      (o_wallet_total)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= S_IDLE;
      r_item           <= '0;
      r_wait_timer     <= '0;
      r_quiet_timer    <= 1'b0;
      r_status         <= STATUS_OK;
      r_req_ready      <= 1'b1;
      r_input_coin     <= '0;
      r_select_item    <= '0;
      r_trigger_return <= 1'b0;
      r_done           <= 1'b0;
    end else begin
      r_input_coin  <= '0;
      r_select_item <= '0;
      r_done        <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && is_single_item(i_req_item)) begin
            r_item      <= i_req_item;
            r_status    <= STATUS_OK;
            r_req_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_avail) begin
            r_select_item <= r_item;
            r_state       <= S_SELECT;
          end else if (w_any) begin
            r_input_coin <= w_pick;
            r_state      <= S_INSERT;
          end else begin
            r_status         <= STATUS_NO_FUNDS;
            r_trigger_return <= 1'b1;
            r_quiet_timer    <= 1'(kQuietCycles - 1);
            r_state          <= S_RETURN;
          end
        end
        S_INSERT: r_state <= S_CHECK;
        S_SELECT: begin
          r_wait_timer <= 2'(kWaitCycles - 1);
          r_state      <= S_WAIT_ITEM;
        end
        S_WAIT_ITEM: begin
          if (i_output_item == r_item) begin
            r_status         <= STATUS_OK;
            r_trigger_return <= 1'b1;
            r_quiet_timer    <= 1'(kQuietCycles - 1);
            r_state          <= S_RETURN;
          end else if (r_wait_timer == '0) begin
            r_status         <= STATUS_TIMEOUT;
            r_trigger_return <= 1'b1;
            r_quiet_timer    <= 1'(kQuietCycles - 1);
            r_state          <= S_RETURN;
          end else begin
            r_wait_timer <= r_wait_timer - 2'd1;
          end
        end
        S_RETURN: begin
          // Any returned coin restarts the quiet window.
          if (i_return_coin != '0) begin
            r_quiet_timer <= 1'(kQuietCycles - 1);
          end else if (r_quiet_timer == 1'b0) begin
            r_trigger_return <= 1'b0;
            r_done           <= 1'b1;
            r_state          <= S_DONE;
          end else begin
            r_quiet_timer <= r_quiet_timer - 1'b1;
          end
        end
        S_DONE: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready      = r_req_ready;
  assign o_input_coin     = r_input_coin;
  assign o_select_item    = r_select_item;
  assign o_trigger_return = r_trigger_return;
  assign o_done           = r_done;
  assign o_status         = r_status;

endmodule
